offchip_line_mem: RTL and testbench
===================================

Name: offchip_line_mem

Overview:
- Off-chip cacheline memory model that sits directly downstream of the outer EBI's L2-side channels.
- Consumes AR, AW and W requests; produces R beats on the registered-input (dff_) read-response port.
- Stores MEM_LINES cachelines plus a 2-bit MESI tag per line.
- Serves as the backing store for NoC/cache/EBI off-chip testbenches.

Parameters:
- DATA_WIDTH, 64, beat width.
- PADDR_WIDTH, 32, physical address width.
- CACHELINE_LENGTH, 512, line size in bits; BEATS = CACHELINE_LENGTH/DATA_WIDTH.
- MEM_LINES, 64, number of stored lines; power of two.
- RD_LATENCY, 4, cycles from AR handshake to first R beat; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- arvalid_i  in  1  read request valid.
- arready_o  out  1  read request accepted.
- arid_i  in  2  read ID.
- araddr_i  in  PADDR_WIDTH  read line address.
- arsnoop_i  in  4  snoop type; ignored.
- awvalid_i  in  1  write request valid.
- awready_o  out  1  write request accepted.
- awaddr_i  in  PADDR_WIDTH  write line address.
- awmesi_i  in  2  new MESI tag for the line.
- wvalid_i  in  1  write beat valid.
- wready_o  out  1  write beat accepted.
- wdata_i  in  DATA_WIDTH  write beat.
- rvalid_o  out  1  read beat valid.
- rready_i  in  1  read beat accepted.
- rid_o  out  2  echoed arid.
- rdata_o  out  DATA_WIDTH  read beat.
- mesi_sta_o  out  2  stored MESI tag of the line being read.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All outputs drive 0.
  - Beat counter and latency counter clear.
  - MESI tag array clears to 2'b00.
  - Data array is not reset; contents survive reset.
  - Reset asserted mid-transfer abandons the transfer immediately; no further beats are produced.
- Line index = addr[log2(CACHELINE_LENGTH/8) +: log2(MEM_LINES)]. Upper address bits are ignored (wrap modulo MEM_LINES). Offset bits are ignored.
- Beat b occupies line bits [b*DATA_WIDTH +: DATA_WIDTH]; beat 0 is sent/received first.
- States: IDLE, RD_WAIT, RD_DATA, WR_DATA.
- IDLE:
  - arready_o = 1.
  - awready_o = !arvalid_i (AR wins when both are valid in the same cycle).
  - AR handshake: latch index and arid, load the latency counter with RD_LATENCY-1, go to RD_WAIT.
  - AW handshake: latch index, write awmesi_i into the tag array, clear the beat counter, go to WR_DATA.
- RD_WAIT:
  - Counter decrements each cycle.
  - At 0, go to RD_DATA with rvalid_o=1 the next cycle.
  - First beat appears exactly RD_LATENCY cycles after the AR handshake.
- RD_DATA:
  - rvalid_o=1; rdata_o = current beat; rid_o = latched ID; mesi_sta_o = tag of the latched line.
  - Outputs are held stable while rready_i=0.
  - Each rvalid&rready advances the beat.
  - Handshake on beat BEATS-1 returns to IDLE; rvalid_o=0 the following cycle.
- WR_DATA:
  - wready_o=1; each wvalid&wready writes the beat into the latched line at the beat-counter position.
  - Handshake on beat BEATS-1 returns to IDLE.
  - While the beat count is 0, arready_o/awready_o follow the IDLE rules. A new AR or AW accepted here ends the write as dataless (tag already updated, data untouched) and is processed exactly as from IDLE.
  - Once beat count > 0, arready_o=awready_o=0 until the line completes.
- Read-after-write to the same line returns the newly written data and tag.
- No concurrent read and write; one outstanding transaction.

Optional Feature:
- OFFCHIP_MEM_BACKPRESSURE_EN defined:
  - A 16-bit LFSR (seed 16'hACE1, advanced every cycle when not in reset) gates arready_o, awready_o and wready_o.
  - Each ready is forced to 0 in cycles where LFSR[1:0]==2'b00.
  - Stresses the handshakes of the upstream EBI.
- Undefined: readies follow the rules above exactly, with no LFSR logic.

Test Plan:
- Reset, then AR addr 0x40 id 2 with rready=1: arready=1 in the same cycle; first rvalid 4 cycles later; 8 consecutive beats of 0 (fresh tags), rid=2, mesi_sta=0; rvalid=0 afterwards.
- AW addr 0x80 mesi 2'b10, then 8 W beats 64'h0..64'h7, then AR 0x80 → beats 0..7 in order, mesi_sta=2'b10.
- Read with rready toggling 1,0,0,1...: rdata/rid held stable during the low cycles; exactly 8 beats delivered, none duplicated.
- AW 0xC0 mesi 2'b01 immediately followed by AR 0xC0 with no W beats: AR accepted; returns old data with mesi_sta=2'b01.
- arvalid and awvalid asserted together in IDLE: only arready handshakes; AW is accepted after the read completes.
- Assert rst during beat 3 of a read: rvalid=0 at once; after release, an AR 0x1040 returns line index 1 (wrap-around), with data intact.

Source files
------------

// File: rtl/offchip_line_mem.sv
// Off-chip cacheline memory model behind the outer EBI: AR/AW/W in, R beats out, MESI tag per line.
// Optional macro OFFCHIP_MEM_BACKPRESSURE_EN adds LFSR-driven ready throttling.
module offchip_line_mem #(
   parameter int DATA_WIDTH       = 64,
   parameter int PADDR_WIDTH      = 32,
   parameter int CACHELINE_LENGTH = 512,
   parameter int MEM_LINES        = 64,
   parameter int RD_LATENCY       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   arvalid_i,
   output logic                   arready_o,
   input  logic [1:0]             arid_i,
   input  logic [PADDR_WIDTH-1:0] araddr_i,
   input  logic [3:0]             arsnoop_i,
   input  logic                   awvalid_i,
   output logic                   awready_o,
   input  logic [PADDR_WIDTH-1:0] awaddr_i,
   input  logic [1:0]             awmesi_i,
   input  logic                   wvalid_i,
   output logic                   wready_o,
   input  logic [DATA_WIDTH-1:0]  wdata_i,
   output logic                   rvalid_o,
   input  logic                   rready_i,
   output logic [1:0]             rid_o,
   output logic [DATA_WIDTH-1:0]  rdata_o,
   output logic [1:0]             mesi_sta_o
);

   localparam int BEATS  = CACHELINE_LENGTH / DATA_WIDTH;
   localparam int OFF_W  = $clog2(CACHELINE_LENGTH / 8);
   localparam int IDX_W  = $clog2(MEM_LINES);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(RD_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_DATA = 2'd2,
      WR_DATA = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [IDX_W-1:0]    idx_r;
   logic [1:0]          id_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [BEAT_W-1:0]   beat_r;
   logic [DATA_WIDTH-1:0] mem_r [MEM_LINES][BEATS];
   logic [1:0]          tag_r [MEM_LINES];

   logic                rdy_en_s;
   logic                ar_hs_s;
   logic                aw_hs_s;
   logic                w_hs_s;
   logic                r_hs_s;
   logic [IDX_W-1:0]    ar_idx_s;
   logic [IDX_W-1:0]    aw_idx_s;
   logic                unused_s;

   assign ar_idx_s = araddr_i[OFF_W +: IDX_W];
   assign aw_idx_s = awaddr_i[OFF_W +: IDX_W];
   assign ar_hs_s  = arvalid_i & arready_o;
   assign aw_hs_s  = awvalid_i & awready_o;
   assign w_hs_s   = wvalid_i & wready_o;
   assign r_hs_s   = rvalid_o & rready_i;
   assign unused_s = ^{arsnoop_i, araddr_i, awaddr_i};

`ifdef OFFCHIP_MEM_BACKPRESSURE_EN
   logic [15:0] lfsr_r;

   // Free-running LFSR that throttles the request-side readies
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_r <= 16'hACE1;
      end else begin
         lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
      end
   end

   assign rdy_en_s = (lfsr_r[1:0] != 2'b00);
`else
   assign rdy_en_s = 1'b1;
`endif

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; AR has priority over AW, both over a pending dataless write
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (ar_hs_s) begin
               state_s = RD_WAIT;
            end else if (aw_hs_s) begin
               state_s = WR_DATA;
            end else begin
               state_s = IDLE;
            end
         end
         RD_WAIT: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_s = RD_DATA;
            end else begin
               state_s = RD_WAIT;
            end
         end
         RD_DATA: begin
            if (r_hs_s && (beat_r == LAST_BEAT)) begin
               state_s = IDLE;
            end else begin
               state_s = RD_DATA;
            end
         end
         WR_DATA: begin
            if (ar_hs_s) begin
               state_s = RD_WAIT;
            end else if (aw_hs_s) begin
               state_s = WR_DATA;
            end else if (w_hs_s && (beat_r == LAST_BEAT)) begin
               state_s = IDLE;
            end else begin
               state_s = WR_DATA;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM outputs; everything is forced low while reset is held
   always_comb begin
      arready_o  = 1'b0;
      awready_o  = 1'b0;
      wready_o   = 1'b0;
      rvalid_o   = 1'b0;
      rid_o      = 2'b00;
      rdata_o    = {DATA_WIDTH{1'b0}};
      mesi_sta_o = 2'b00;
      if (rst) begin
         arready_o = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               arready_o = rdy_en_s;
               awready_o = rdy_en_s & ~arvalid_i;
            end
            RD_DATA: begin
               rvalid_o   = 1'b1;
               rid_o      = id_r;
               rdata_o    = mem_r[idx_r][beat_r];
               mesi_sta_o = tag_r[idx_r];
            end
            WR_DATA: begin
               if (beat_r == {BEAT_W{1'b0}}) begin
                  // A new request here turns the write dataless, so W is held off
                  arready_o = rdy_en_s;
                  awready_o = rdy_en_s & ~arvalid_i;
                  wready_o  = rdy_en_s & ~(arvalid_i | awvalid_i);
               end else begin
                  wready_o = rdy_en_s;
               end
            end
            default: arready_o = 1'b0;
         endcase
      end
   end

   // Latched line index, ID, latency counter and beat counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r  <= {IDX_W{1'b0}};
         id_r   <= 2'b00;
         cnt_r  <= {CNT_W{1'b0}};
         beat_r <= {BEAT_W{1'b0}};
      end else if (ar_hs_s) begin
         idx_r  <= ar_idx_s;
         id_r   <= arid_i;
         cnt_r  <= LAT_LOAD;
         beat_r <= {BEAT_W{1'b0}};
      end else if (aw_hs_s) begin
         idx_r  <= aw_idx_s;
         beat_r <= {BEAT_W{1'b0}};
      end else if ((state_r == RD_WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else if (r_hs_s || w_hs_s) begin
         beat_r <= (beat_r == LAST_BEAT) ? {BEAT_W{1'b0}} : beat_r + BEAT_W'(1);
      end
   end

   // MESI tag array, cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_LINES; i++) begin
            tag_r[i] <= 2'b00;
         end
      end else if (aw_hs_s) begin
         tag_r[aw_idx_s] <= awmesi_i;
      end
   end

   // Line data array; deliberately not reset so contents survive rst
   always_ff @(posedge clk) begin
      if (w_hs_s) begin
         mem_r[idx_r][beat_r] <= wdata_i;
      end
   end

endmodule

// File: tb/tb_offchip_line_mem.sv
// Directed self-checking bench for offchip_line_mem (default build, no backpressure).
module tb_offchip_line_mem;

   logic        clk;
   logic        rst;
   logic        arvalid;
   logic        arready;
   logic [1:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arsnoop;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [1:0]  awmesi;
   logic        wvalid;
   logic        wready;
   logic [63:0] wdata;
   logic        rvalid;
   logic        rready;
   logic [1:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  mesi_sta;

   int checks   = 0;
   int failures = 0;

   offchip_line_mem dut (
      .clk       (clk),
      .rst       (rst),
      .arvalid_i (arvalid),
      .arready_o (arready),
      .arid_i    (arid),
      .araddr_i  (araddr),
      .arsnoop_i (arsnoop),
      .awvalid_i (awvalid),
      .awready_o (awready),
      .awaddr_i  (awaddr),
      .awmesi_i  (awmesi),
      .wvalid_i  (wvalid),
      .wready_o  (wready),
      .wdata_i   (wdata),
      .rvalid_o  (rvalid),
      .rready_i  (rready),
      .rid_o     (rid),
      .rdata_o   (rdata),
      .mesi_sta_o(mesi_sta)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic aw_req(input logic [31:0] addr, input logic [1:0] mesi);
      awvalid = 1'b1;
      awaddr  = addr;
      awmesi  = mesi;
      #1;
      check_eq("aw_ready", {63'd0, awready}, 64'd1);
      step();
      awvalid = 1'b0;
   endtask

   task automatic w_beats(input logic [63:0] base, input logic [63:0] inc);
      for (int b = 0; b < 8; b++) begin
         wvalid = 1'b1;
         wdata  = base + 64'(b) * inc;
         #1;
         check_eq("w_ready", {63'd0, wready}, 64'd1);
         step();
      end
      wvalid = 1'b0;
   endtask

   // Issues an AR, checks latency, then consumes nb beats (expected data base+b*inc)
   task automatic read_line(input logic [31:0] addr, input logic [1:0] id, input logic [1:0] mesi,
                            input logic [63:0] base, input logic [63:0] inc,
                            input bit toggle, input int nb);
      int lat;
      int b;
      int k;
      arvalid = 1'b1;
      araddr  = addr;
      arid    = id;
      #1;
      check_eq("ar_ready", {63'd0, arready}, 64'd1);
      step();
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 20) begin
         step();
         lat++;
      end
      check_eq("rd_latency", 64'(lat), 64'd4);
      b = 0;
      k = 0;
      while (b < nb && k < 100) begin
         rready = toggle ? ((k % 3) == 0) : 1'b1;
         #1;
         check_eq("r_valid", {63'd0, rvalid}, 64'd1);
         check_eq("r_data", rdata, base + 64'(b) * inc);
         check_eq("r_id", {62'd0, rid}, {62'd0, id});
         check_eq("r_mesi", {62'd0, mesi_sta}, {62'd0, mesi});
         check_eq("r_awready_low", {63'd0, awready}, 64'd0);
         if (rready) b++;
         k++;
         step();
      end
      check_eq("r_beat_count", 64'(b), 64'(nb));
      if (nb == 8) begin
         rready = 1'b0;
         #1;
         check_eq("r_valid_end", {63'd0, rvalid}, 64'd0);
      end
   endtask

   initial begin
      rst = 1'b1; arvalid = 1'b0; arid = 2'd0; araddr = 32'd0; arsnoop = 4'd0;
      awvalid = 1'b0; awaddr = 32'd0; awmesi = 2'd0; wvalid = 1'b0; wdata = 64'd0;
      rready = 1'b0;
      step();
      #1;
      check_eq("rst_arready", {63'd0, arready}, 64'd0);
      check_eq("rst_awready", {63'd0, awready}, 64'd0);
      check_eq("rst_wready", {63'd0, wready}, 64'd0);
      check_eq("rst_rvalid", {63'd0, rvalid}, 64'd0);
      step();
      rst = 1'b0;
      step();

      // Preload: line 1 all zeros, line 3 a known pattern; data must survive the next reset
      aw_req(32'h40, 2'b11);
      w_beats(64'd0, 64'd0);
      aw_req(32'hC0, 2'b11);
      w_beats(64'hA5A5_0000_0000_0000, 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();

      // 1: zero line, fresh tag
      read_line(32'h40, 2'd2, 2'b00, 64'd0, 64'd0, 1'b0, 8);
      step();

      // 2: write then read back line 2
      aw_req(32'h80, 2'b10);
      w_beats(64'd0, 64'd1);
      read_line(32'h80, 2'd1, 2'b10, 64'd0, 64'd1, 1'b0, 8);
      step();

      // 3: rready toggling
      read_line(32'h80, 2'd3, 2'b10, 64'd0, 64'd1, 1'b1, 8);
      step();

      // 4: dataless write interrupted by AR
      aw_req(32'hC0, 2'b01);
      arvalid = 1'b1;
      araddr  = 32'hC0;
      #1;
      check_eq("wr0_awready", {63'd0, awready}, 64'd0);
      check_eq("wr0_wready", {63'd0, wready}, 64'd0);
      read_line(32'hC0, 2'd0, 2'b01, 64'hA5A5_0000_0000_0000, 64'd1, 1'b0, 8);
      step();

      // 5: AR and AW together, AW waits for the read
      awvalid = 1'b1;
      awaddr  = 32'h40;
      awmesi  = 2'b11;
      arvalid = 1'b1;
      araddr  = 32'h80;
      #1;
      check_eq("both_awready", {63'd0, awready}, 64'd0);
      read_line(32'h80, 2'd1, 2'b10, 64'd0, 64'd1, 1'b0, 8);
      aw_req(32'h40, 2'b11);
      w_beats(64'h1111_0000_0000_0000, 64'd1);
      read_line(32'h40, 2'd0, 2'b11, 64'h1111_0000_0000_0000, 64'd1, 1'b0, 8);
      step();

      // 6: reset during beat 3, then wrapped address to line 1
      read_line(32'h80, 2'd2, 2'b10, 64'd0, 64'd1, 1'b0, 3);
      #1;
      check_eq("mid_rdata", rdata, 64'd3);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
      check_eq("mid_rst_rdata", rdata, 64'd0);
      check_eq("mid_rst_arready", {63'd0, arready}, 64'd0);
      rready = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      check_eq("post_rst_rvalid", {63'd0, rvalid}, 64'd0);
      step();
      read_line(32'h1040, 2'd1, 2'b00, 64'h1111_0000_0000_0000, 64'd1, 1'b0, 8);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
